// File: rtl/logic_unit_pkg.sv
// Shared types for the logic unit pipeline: opcode encoding and result buffer depth.
package logic_unit_pkg;

   typedef enum logic [2:0] {
      LU_AND  = 3'd0,
      LU_OR   = 3'd1,
      LU_NOT  = 3'd2,
      LU_NAND = 3'd3,
      LU_NOR  = 3'd4,
      LU_XOR  = 3'd5,
      LU_XNOR = 3'd6,
      LU_PASS = 3'd7
   } lu_op_e;

   localparam int LU_BUF_DEPTH = 2;

endpackage

// File: rtl/lu_skid_buf.sv
// Two-entry FIFO skid buffer with valid/ready handshake on both sides.
// in_ready is registered from the next occupancy, so it never depends on out_ready combinationally.
module lu_skid_buf
   import logic_unit_pkg::*;
#(
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [PW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [PW-1:0] out_data
);

   localparam int PTR_W = (LU_BUF_DEPTH > 1) ? $clog2(LU_BUF_DEPTH) : 1;
   localparam int OCC_W = $clog2(LU_BUF_DEPTH + 1);

   logic [PW-1:0]    mem [LU_BUF_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [OCC_W-1:0] occ;
   logic [OCC_W-1:0] occ_next;
   logic             ready_reg;
   logic             push;
   logic             pop;

   assign push      = in_valid & ready_reg;
   assign pop       = (occ != '0) & out_ready;
   assign in_ready  = ready_reg;
   assign out_valid = (occ != '0);
   assign out_data  = mem[rd_ptr];

   always_comb begin
      occ_next = occ;
      case ({push, pop})
         2'b10:   occ_next = occ + OCC_W'(1);
         2'b01:   occ_next = occ - OCC_W'(1);
         default: occ_next = occ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ       <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ready_reg <= 1'b0;
         for (int i = 0; i < LU_BUF_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         occ       <= occ_next;
         ready_reg <= (occ_next < OCC_W'(LU_BUF_DEPTH));
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= (wr_ptr == PTR_W'(LU_BUF_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_W'(LU_BUF_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
         end
      end
   end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: result computed at input, buffered in a 2-entry skid buffer.
// Optional zero/parity flags are built only when LOGIC_UNIT_FLAGS_EN is defined.
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  lu_op_e           in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output lu_op_e           out_op,
   output logic             out_zero,
   output logic             out_parity,
   output logic [CNT_W-1:0] txn_count
);

`ifdef LOGIC_UNIT_FLAGS_EN
   localparam int PW = WIDTH + 3 + 2;
`else
   localparam int PW = WIDTH + 3;
`endif

   logic [WIDTH-1:0] y_calc;
   logic [PW-1:0]    buf_in;
   logic [PW-1:0]    buf_out;
   logic [CNT_W-1:0] count_reg;

   always_comb begin
      y_calc = '0;
      case (in_op)
         LU_AND:  y_calc = in_a & in_b;
         LU_OR:   y_calc = in_a | in_b;
         LU_NOT:  y_calc = ~in_a;
         LU_NAND: y_calc = ~(in_a & in_b);
         LU_NOR:  y_calc = ~(in_a | in_b);
         LU_XOR:  y_calc = in_a ^ in_b;
         LU_XNOR: y_calc = ~(in_a ^ in_b);
         LU_PASS: y_calc = in_a;
         default: y_calc = '0;
      endcase
   end

`ifdef LOGIC_UNIT_FLAGS_EN
   // Flags ride alongside the result so they stay aligned through the buffer.
   assign buf_in     = {(y_calc == '0), ^y_calc, 3'(in_op), y_calc};
   assign out_zero   = buf_out[WIDTH+4];
   assign out_parity = buf_out[WIDTH+3];
`else
   assign buf_in     = {3'(in_op), y_calc};
   assign out_zero   = 1'b0;
   assign out_parity = 1'b0;
`endif

   assign out_y  = buf_out[WIDTH-1:0];
   assign out_op = lu_op_e'(buf_out[WIDTH+2:WIDTH]);

   lu_skid_buf #(
      .PW (PW)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (buf_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (buf_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (out_valid && out_ready && (count_reg != '1)) begin
         count_reg <= count_reg + CNT_W'(1);
      end
   end

   assign txn_count = count_reg;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe (WIDTH=8); a second instance with CNT_W=2 covers counter saturation.
module tb_logic_unit_pipe;
   import logic_unit_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   lu_op_e     in_op = LU_AND;
   logic [7:0] in_a = 8'h00;
   logic [7:0] in_b = 8'h00;

   logic        in_ready, out_valid, out_zero, out_parity;
   logic [7:0]  out_y;
   lu_op_e      out_op;
   logic [15:0] txn_count;

   logic        s_in_ready, s_out_valid, s_out_zero, s_out_parity;
   logic [7:0]  s_out_y;
   lu_op_e      s_out_op;
   logic [1:0]  s_txn_count;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [2:0] op;
      logic [7:0] y;
   } exp_t;

   exp_t       q[$];
   int         exp_cnt = 0;
   int         sat_exp = 0;
   logic       pop_seen = 1'b0;
   logic       pop_exp_ok = 1'b0;
   exp_t       pop_exp;
   logic [7:0] pop_y;
   logic [2:0] pop_op;
   logic       pop_z, pop_p;

   logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
      .out_ready(out_ready), .out_y(out_y), .out_op(out_op), .out_zero(out_zero),
      .out_parity(out_parity), .txn_count(txn_count)
   );

   logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(s_out_valid),
      .out_ready(out_ready), .out_y(s_out_y), .out_op(s_out_op), .out_zero(s_out_zero),
      .out_parity(s_out_parity), .txn_count(s_txn_count)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ref_op(int op, logic [7:0] a, logic [7:0] b);
      case (op)
         0: return a & b;
         1: return a | b;
         2: return ~a;
         3: return ~(a & b);
         4: return ~(a | b);
         5: return a ^ b;
         6: return ~(a ^ b);
         7: return a;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic exp_zero(logic [7:0] y);
`ifdef LOGIC_UNIT_FLAGS_EN
      return (y == 8'h00);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic exp_parity(logic [7:0] y);
`ifdef LOGIC_UNIT_FLAGS_EN
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(y[i]);
      return (ones % 2) == 1;
`else
      return 1'b0;
`endif
   endfunction

   // Advance one clock, updating the reference queue with whatever handshakes happen at the edge.
   task automatic step();
      logic push, pop;
      push = in_valid && in_ready;
      pop  = out_valid && out_ready;
      pop_seen = pop;
      pop_y = out_y; pop_op = 3'(out_op); pop_z = out_zero; pop_p = out_parity;
      pop_exp_ok = 1'b0;
      pop_exp = '0;
      if (pop && q.size() > 0) begin
         pop_exp = q.pop_front();
         pop_exp_ok = 1'b1;
      end
      if (pop) begin
         if (exp_cnt < 65535) exp_cnt++;
         if (sat_exp < 3) sat_exp++;
      end
      if (push) q.push_back({3'(in_op), ref_op(int'(in_op), in_a, in_b)});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || txn_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_ctrl: in_ready=%b out_valid=%b txn_count=%0d, required 0 0 0", in_ready, out_valid, txn_count);
      end
      checks++;
      if (out_y !== 8'h00 || 3'(out_op) !== 3'd0 || out_zero !== 1'b0 || out_parity !== 1'b0) begin
         errors++;
         $display("FAIL reset_data: out_y=%h out_op=%0d zero=%b parity=%b, required 00 0 0 0", out_y, out_op, out_zero, out_parity);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
      end
      $display("test_reset done");
   endtask

   task automatic test_sweep();
      logic [7:0] table_y [8] = '{8'h81, 8'hE7, 8'h3C, 8'h7E, 8'h18, 8'h66, 8'h99, 8'hC3};
      out_ready = 1'b1;
      in_a = 8'hC3;
      in_b = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_op = lu_op_e'(i);
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL sweep_ready op=%0d: in_ready=%b, required 1", i, in_ready);
         end
         step();
         checks++;
         if (out_valid !== 1'b1 || out_y !== table_y[i] || 3'(out_op) !== 3'(i) ||
             out_zero !== exp_zero(table_y[i]) || out_parity !== exp_parity(table_y[i])) begin
            errors++;
            $display("FAIL sweep_result op=%0d: valid=%b y=%h op=%0d z=%b p=%b, required 1 %h %0d %b %b",
                     i, out_valid, out_y, out_op, out_zero, out_parity, table_y[i], i,
                     exp_zero(table_y[i]), exp_parity(table_y[i]));
         end
         $display("sweep op=%0d y=%h", i, out_y);
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b0 || q.size() != 0) begin
         errors++;
         $display("FAIL sweep_drain: out_valid=%b queued=%0d, required 0 0", out_valid, q.size());
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_op = lu_op_e'($urandom_range(0, 7));
         in_a = 8'($urandom);
         in_b = 8'($urandom);
         step();
      end
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_full: in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || txn_count !== 16'd0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: out_valid=%b txn_count=%0d in_ready=%b, required 0 0 0", out_valid, txn_count, in_ready);
      end
      q.delete();
      exp_cnt = 0;
      sat_exp = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || txn_count !== 16'd0) begin
         errors++;
         $display("FAIL mid_release: in_ready=%b out_valid=%b txn_count=%0d, required 1 0 0", in_ready, out_valid, txn_count);
      end
      $display("test_reset_mid done");
   endtask

   task automatic test_backpressure();
      lu_op_e     r_op [3];
      logic [7:0] r_a [3];
      logic [7:0] r_b [3];
      int idx = 0;
      int pops = 0;
      logic acc;
      for (int i = 0; i < 3; i++) begin
         r_op[i] = lu_op_e'($urandom_range(0, 7));
         r_a[i] = 8'($urandom);
         r_b[i] = 8'($urandom);
      end
      out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         in_valid = (idx < 3);
         if (idx < 3) begin in_op = r_op[idx]; in_a = r_a[idx]; in_b = r_b[idx]; end
         acc = in_valid && in_ready;
         step();
         if (acc) idx++;
      end
      checks++;
      if (idx != 2 || in_ready !== 1'b0 || out_valid !== 1'b1 || q.size() != 2 || out_y !== q[0].y) begin
         errors++;
         $display("FAIL bp_stall: accepted=%0d in_ready=%b out_valid=%b out_y=%h, required 2 0 1 %h",
                  idx, in_ready, out_valid, out_y, (q.size() > 0) ? q[0].y : 8'h00);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 20 && (idx < 3 || q.size() > 0); c++) begin
         in_valid = (idx < 3);
         if (idx < 3) begin in_op = r_op[idx]; in_a = r_a[idx]; in_b = r_b[idx]; end
         acc = in_valid && in_ready;
         step();
         if (acc) idx++;
         if (pop_seen) begin
            pops++;
            checks++;
            if (!pop_exp_ok || pop_y !== pop_exp.y || pop_op !== pop_exp.op) begin
               errors++;
               $display("FAIL bp_order #%0d: y=%h op=%0d, required %h %0d", pops, pop_y, pop_op, pop_exp.y, pop_exp.op);
            end
            $display("bp pop #%0d y=%h op=%0d", pops, pop_y, pop_op);
         end
      end
      in_valid = 1'b0;
      checks++;
      if (pops != 3 || txn_count !== 16'd3) begin
         errors++;
         $display("FAIL bp_count: pops=%0d txn_count=%0d, required 3 3", pops, txn_count);
      end
   endtask

   task automatic test_flags();
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_a = 8'h0F;
      in_b = 8'hF0;
      in_op = LU_AND;
      step();
      checks++;
`ifdef LOGIC_UNIT_FLAGS_EN
      if (out_valid !== 1'b1 || out_y !== 8'h00 || out_zero !== 1'b1 || out_parity !== 1'b0) begin
         errors++;
         $display("FAIL flags_and: valid=%b y=%h z=%b p=%b, required 1 00 1 0", out_valid, out_y, out_zero, out_parity);
      end
`else
      if (out_valid !== 1'b1 || out_y !== 8'h00 || out_zero !== 1'b0 || out_parity !== 1'b0) begin
         errors++;
         $display("FAIL flags_and: valid=%b y=%h z=%b p=%b, required 1 00 0 0", out_valid, out_y, out_zero, out_parity);
      end
`endif
      $display("flags AND y=%h z=%b p=%b", out_y, out_zero, out_parity);
      in_op = LU_OR;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_y !== 8'hFF || out_zero !== 1'b0 || out_parity !== 1'b0) begin
         errors++;
         $display("FAIL flags_or: valid=%b y=%h z=%b p=%b, required 1 FF 0 0", out_valid, out_y, out_zero, out_parity);
      end
      $display("flags OR y=%h z=%b p=%b", out_y, out_zero, out_parity);
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_op = lu_op_e'($urandom_range(0, 7));
         in_a = 8'($urandom);
         in_b = 8'($urandom);
         if ((c % 37) == 0) begin in_a = 8'h00; in_b = 8'h00; end
         checks++;
         if (in_ready !== (q.size() < 2) || out_valid !== (q.size() != 0)) begin
            errors++;
            $display("FAIL rand_hs c=%0d: in_ready=%b out_valid=%b, required %b %b", c, in_ready, out_valid, q.size() < 2, q.size() != 0);
         end
         if (q.size() > 0) begin
            checks++;
            if (out_y !== q[0].y || 3'(out_op) !== q[0].op ||
                out_zero !== exp_zero(q[0].y) || out_parity !== exp_parity(q[0].y)) begin
               errors++;
               $display("FAIL rand_head c=%0d: y=%h op=%0d z=%b p=%b, required %h %0d %b %b", c, out_y, out_op,
                        out_zero, out_parity, q[0].y, q[0].op, exp_zero(q[0].y), exp_parity(q[0].y));
            end
         end
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) step();
      checks++;
      if (out_valid !== 1'b0 || q.size() != 0 || txn_count !== 16'(exp_cnt)) begin
         errors++;
         $display("FAIL rand_end: out_valid=%b txn_count=%0d, required 0 %0d", out_valid, txn_count, exp_cnt);
      end
      $display("test_random done transfers=%0d", exp_cnt);
   endtask

   task automatic test_saturation();
      rst_n = 1'b0;
      #2;
      q.delete();
      exp_cnt = 0;
      sat_exp = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_valid = (k < 5);
         in_op = lu_op_e'($urandom_range(0, 7));
         in_a = 8'($urandom);
         in_b = 8'($urandom);
         step();
         checks++;
         if (s_txn_count !== 2'(sat_exp)) begin
            errors++;
            $display("FAIL sat_step k=%0d: txn_count=%0d, required %0d", k, s_txn_count, sat_exp);
         end
      end
      in_valid = 1'b0;
      checks++;
      if (s_txn_count !== 2'd3 || txn_count !== 16'd5) begin
         errors++;
         $display("FAIL sat_final: sat_count=%0d main_count=%0d, required 3 5", s_txn_count, txn_count);
      end
      $display("saturation sat_count=%0d main_count=%0d", s_txn_count, txn_count);
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_reset_mid();
      test_backpressure();
      test_flags();
      test_random();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit, required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (>=1).
REQ-002 Parameter CNT_W, default 16, width of the completed-transaction counter (>=2).
REQ-003 Ports: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  upstream request valid.
REQ-007 in_ready  output  1  block can accept a request this cycle.
REQ-008 in_op  input  3  opcode, typed as the package enum.
REQ-009 in_a  input  WIDTH  operand A.
REQ-010 in_b  input  WIDTH  operand B (ignored for NOT and PASS).
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_y  output  WIDTH  bitwise result.
REQ-014 out_op  output  3  opcode that produced out_y.
REQ-015 out_zero  output  1  out_y is all zeros (feature-gated, see Configuration).
REQ-016 out_parity  output  1  XOR-reduction of out_y (feature-gated).
REQ-017 txn_count  output  CNT_W  number of completed output transfers.

Function
REQ-018 Opcodes: 0 AND, 1 OR, 2 NOT a, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS a; all bitwise over WIDTH bits.
REQ-019 Input transfer occurs on a rising edge with in_valid and in_ready both high; output transfer occurs with out_valid and out_ready both high.
REQ-020 Result is computed combinationally at input and stored in a 2-entry FIFO skid buffer; latency is exactly 1 cycle from input transfer to out_valid when the buffer is empty.
REQ-021 in_ready is a registered signal, high when buffer occupancy < 2; it has no combinational path from out_ready.
REQ-022 Sustained throughput is one transfer per cycle when out_ready is held high.
REQ-023 Results leave in acceptance order; none dropped or duplicated.
REQ-024 While out_valid is high and out_ready low, out_y, out_op, out_zero and out_parity hold stable.
REQ-025 Simultaneous input and output transfer leaves occupancy unchanged, including at occupancy 1.
REQ-026 At occupancy 2, in_ready is low; an output transfer that cycle raises in_ready on the next cycle.
REQ-027 txn_count increments by 1 on each output transfer and saturates at all-ones.

Reset
REQ-028 Reset asserted: buffer emptied, in_ready 0 while asserted, out_valid 0, out_y 0, out_op 0, out_zero 0, out_parity 0, txn_count 0.
REQ-029 First cycle after deassertion: in_ready 1; any in-flight results are discarded by a reset mid-operation.

Configuration
REQ-030 Macro LOGIC_UNIT_FLAGS_EN defined: out_zero and out_parity are computed at input, stored per buffer entry, and presented with out_y.
REQ-031 Macro undefined: no flag storage is built; out_zero and out_parity are tied to 0; all other behaviour identical.

Structure
REQ-032 Package logic_unit_pkg holds the 3-bit opcode enum lu_op_e and the localparam for buffer depth (2).
REQ-033 One sub-module, lu_skid_buf, parametrised on payload width, implements the 2-entry buffer and handshake; the top holds the op decode, flag logic and counter.

Verification (WIDTH=8)
REQ-034 Reset: rst_n low mid-stream with 2 entries buffered -> out_valid 0, txn_count 0, in_ready 1 one cycle after release.
REQ-035 Opcode sweep: a=8'hC3, b=8'hA5, ops 0..7 with out_ready=1 -> out_y 81,E7,3C,7E,18,66,99,C3 in order, one per cycle, latency 1.
REQ-036 Backpressure: out_ready=0, send 3 requests -> 2 accepted, in_ready low, third held; release out_ready -> 3 results in order, txn_count 3.
REQ-037 Flags (macro defined): a=8'h0F, b=8'hF0, op AND -> out_y 00, out_zero 1, out_parity 0; op OR -> out_y FF, out_zero 0, out_parity 0; macro undefined -> both flags 0.
REQ-038 Counter saturation with CNT_W=2: 5 output transfers -> txn_count 3 and remains 3.
